sram_param_train: RTL and testbench

Parametrised single-port synchronous SRAM: the next generation of the 8-wide/16-deep boot/train SRAM. Adds generic width and depth, a self-running training sequencer (pattern fill plus read-back check with pass/fail), a boot-mode write lock, out-of-range address detection, and a registered read with valid strobe. It sits between the boot/config controller and the datapath as a small scratch/config store.

---
 rtl/sram_param_train.sv | 213 +++++++++++++++++++++
 tb/tb_sram_param_train.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_param_train.sv
`default_nettype none
// ============================================================================
// Module   : sram_param_train
// Brief    : Parametrised single-port synchronous SRAM with a registered read
//            and valid strobe, boot-mode write lock, out-of-range detection,
//            and a self-running training sequencer (pattern fill + check).
// Revision : 1.0 - initial release
// ============================================================================
module sram_param_train #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 16,
    parameter int               ADDR      = 16,
    parameter logic [WIDTH-1:0] TRAIN_PAT = WIDTH'(8'hA5)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wren,
    input  logic             rden,
    input  logic             boot_mode,
    input  logic             train_mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [ADDR-1:0]  addr,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             acc_err,
    output logic             train_busy,
    output logic             train_done,
    output logic             train_pass
);

    // Counter/index width and the last valid word index.
    localparam int              c_CW   = $clog2(DEPTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEPTH - 1);

    // DEPTH held one bit wider than the address so 2^ADDR == DEPTH still compares correctly.
    localparam int              c_AXW     = ADDR + 1;
    localparam logic [ADDR:0]   c_DEPTH_X = c_AXW'(DEPTH);

    // Training sequencer states.
    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_TWR  = 3'd1;
    localparam logic [2:0] c_S_TRD  = 3'd2;
    localparam logic [2:0] c_S_TCHK = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic             r_fail;
    logic             r_pass;
    logic             r_chk_vld;
    logic [WIDTH-1:0] r_chk_exp;
    logic [WIDTH-1:0] r_trd_data;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_dout;
    logic             r_rd_valid;
    logic             r_acc_err;

    logic             w_busy;
    logic             w_done;
    logic             w_in_range;
    logic [c_CW-1:0]  w_addr_idx;
    logic             w_fn_ok;
    logic             w_fn_wr;
    logic             w_fn_rd;
    logic             w_fn_err;
    logic             w_tr_wr;
    logic             w_tr_rd;
    logic [WIDTH-1:0] w_cnt_pat;
    logic             w_mismatch;
    logic             w_fail_nxt;
    logic             w_we;
    logic [c_CW-1:0]  w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [c_CW-1:0]  w_raddr;
    logic [WIDTH-1:0] w_rdata;

    // Functional access is only honoured while the sequencer is parked in IDLE.
    assign w_in_range = ({1'b0, addr} < c_DEPTH_X);
    assign w_addr_idx = addr[c_CW-1:0];
    assign w_fn_ok    = (r_state == c_S_IDLE) && !train_mode;
    assign w_fn_wr    = w_fn_ok && wren && !boot_mode && w_in_range;
    assign w_fn_rd    = w_fn_ok && rden && w_in_range;
    assign w_fn_err   = w_fn_ok && (((wren || rden) && !w_in_range) || (wren && boot_mode));

    // Training steps only advance while train_mode is still held; dropping it aborts.
    assign w_tr_wr    = (r_state == c_S_TWR) && train_mode;
    assign w_tr_rd    = (r_state == c_S_TRD) && train_mode;
    assign w_cnt_pat  = TRAIN_PAT ^ WIDTH'(r_cnt);

    // Read-back compare runs one cycle behind the read issue.
    assign w_mismatch = r_chk_vld && (r_trd_data != r_chk_exp);
    assign w_fail_nxt = r_fail || w_mismatch;

    // Single write port and single read port shared between sequencer and user.
    assign w_we    = !rst && (w_tr_wr || w_fn_wr);
    assign w_waddr = w_tr_wr ? r_cnt : w_addr_idx;
    assign w_wdata = w_tr_wr ? w_cnt_pat : data_in;
    assign w_raddr = w_tr_rd ? r_cnt : w_addr_idx;
    assign w_rdata = r_mem[w_raddr];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: any stage falls back to IDLE when train_mode drops.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (train_mode) w_state_nxt = c_S_TWR;
            c_S_TWR: begin
                if (!train_mode)           w_state_nxt = c_S_IDLE;
                else if (r_cnt == c_LAST)  w_state_nxt = c_S_TRD;
            end
            c_S_TRD: begin
                if (!train_mode)           w_state_nxt = c_S_IDLE;
                else if (r_cnt == c_LAST)  w_state_nxt = c_S_TCHK;
            end
            c_S_TCHK: w_state_nxt = train_mode ? c_S_DONE : c_S_IDLE;
            c_S_DONE: if (!train_mode) w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Output decode of the sequencer state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_S_TWR, c_S_TRD, c_S_TCHK: w_busy = 1'b1;
            c_S_DONE:                   w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Word counter: walks 0..DEPTH-1 in TWR and again in TRD, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tr_wr || w_tr_rd) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Read-back pipeline and sticky fail flag, cleared whenever the sequencer idles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_vld  <= 1'b0;
            r_chk_exp  <= '0;
            r_trd_data <= '0;
            r_fail     <= 1'b0;
        end else begin
            r_chk_vld  <= w_tr_rd;
            r_chk_exp  <= w_cnt_pat;
            r_trd_data <= w_rdata;
            r_fail     <= (r_state == c_S_IDLE) ? 1'b0 : w_fail_nxt;
        end
    end

    // Pass flag: captured on the final compare, held through DONE, cleared elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if ((r_state == c_S_TCHK) && train_mode) begin
            r_pass <= ~w_fail_nxt;
        end else if ((r_state == c_S_DONE) && train_mode) begin
            r_pass <= r_pass;
        end else begin
            r_pass <= 1'b0;
        end
    end

    // Functional read data, valid strobe and access-error strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
            r_acc_err  <= 1'b0;
        end else begin
            r_rd_valid <= w_fn_rd;
            r_acc_err  <= w_fn_err;
            if (w_fn_rd) begin
                r_dout <= w_rdata;
            end
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign data_out   = r_dout;
    assign rd_valid   = r_rd_valid;
    assign acc_err    = r_acc_err;
    assign train_busy = w_busy;
    assign train_done = w_done;
    assign train_pass = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_sram_param_train.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_param_train
// Brief    : Self-checking bench for sram_param_train (vector table, training
//            sequences and randomized accesses against a behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_param_train;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 16;
    localparam int         ADDR  = 16;
    localparam logic [7:0] PAT   = 8'hA5;
    localparam int         TRAIN_EDGES = 2 * DEPTH + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wren;
    logic             rden;
    logic             boot_mode;
    logic             train_mode;
    logic [WIDTH-1:0] data_in;
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             acc_err;
    logic             train_busy;
    logic             train_done;
    logic             train_pass;

    int errors = 0;
    int checks = 0;

    // Behavioural model: plain array of words plus the last returned read word.
    logic [7:0] model_mem [DEPTH];
    logic [7:0] model_dout;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       bt;
        logic [15:0] a;
        logic [7:0] din;
        logic       vld;
        logic       err;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];

    sram_param_train #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR      (ADDR),
        .TRAIN_PAT (PAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wren       (wren),
        .rden       (rden),
        .boot_mode  (boot_mode),
        .train_mode (train_mode),
        .data_in    (data_in),
        .addr       (addr),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .acc_err    (acc_err),
        .train_busy (train_busy),
        .train_done (train_done),
        .train_pass (train_pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic bt,
                                input logic [15:0] a, input logic [7:0] din,
                                input logic vld, input logic err, input logic [7:0] dout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.bt = bt; v.a = a; v.din = din;
        v.vld = vld; v.err = err; v.dout = dout;
        return v;
    endfunction

    task automatic idle_inputs();
        wren = 1'b0; rden = 1'b0; boot_mode = 1'b0; train_mode = 1'b0;
        data_in = '0; addr = '0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_dout = 8'h00;
        check({tag, ".data_out"},   32'(data_out),   32'h0);
        check({tag, ".rd_valid"},   32'(rd_valid),   32'h0);
        check({tag, ".acc_err"},    32'(acc_err),    32'h0);
        check({tag, ".train_busy"}, 32'(train_busy), 32'h0);
        check({tag, ".train_done"}, 32'(train_done), 32'h0);
        check({tag, ".train_pass"}, 32'(train_pass), 32'h0);
    endtask

    // One functional cycle predicted from the access rules, then checked.
    task automatic step(input logic wr, input logic rd, input logic bt,
                        input logic [15:0] a, input logic [7:0] d, input string tag);
        logic inr;
        logic e_vld;
        logic e_err;
        inr   = (int'(a) < DEPTH);
        e_vld = rd && inr;
        e_err = ((wr || rd) && !inr) || (wr && bt);
        if (e_vld) model_dout = model_mem[int'(a)];
        @(negedge clk);
        wren = wr; rden = rd; boot_mode = bt; train_mode = 1'b0;
        addr = a; data_in = d;
        @(posedge clk);
        #1;
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_vld));
        check({tag, ".acc_err"},  32'(acc_err),  32'(e_err));
        check({tag, ".data_out"}, 32'(data_out), 32'(model_dout));
        if (wr && !bt && inr) model_mem[int'(a)] = d;
    endtask

    // Full training run; optionally corrupts the read-back of word 5.
    task automatic run_training(input logic corrupt, input logic exp_pass, input string tag);
        @(negedge clk);
        // Functional requests held active throughout must be ignored.
        wren = 1'b1; rden = 1'b1; boot_mode = 1'b0; addr = 16'd3; data_in = 8'h00;
        train_mode = 1'b1;
        for (int k = 1; k <= TRAIN_EDGES; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s.busy@%0d", tag, k), 32'(train_busy), 32'(k <= TRAIN_EDGES - 1));
            check($sformatf("%s.done@%0d", tag, k), 32'(train_done), 32'(k == TRAIN_EDGES));
            check($sformatf("%s.vld@%0d", tag, k),  32'(rd_valid),   32'h0);
            check($sformatf("%s.err@%0d", tag, k),  32'(acc_err),    32'h0);
            if (corrupt && k == 2 + DEPTH + 5) force dut.r_trd_data = 8'h00;
            if (corrupt && k == 3 + DEPTH + 5) release dut.r_trd_data;
        end
        check({tag, ".pass"}, 32'(train_pass), 32'(exp_pass));
        @(posedge clk);
        #1;
        check({tag, ".done_hold"}, 32'(train_done), 32'h1);
        check({tag, ".pass_hold"}, 32'(train_pass), 32'(exp_pass));
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check({tag, ".done_clr"}, 32'(train_done), 32'h0);
        check({tag, ".pass_clr"}, 32'(train_pass), 32'h0);
        check({tag, ".busy_clr"}, 32'(train_busy), 32'h0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = PAT ^ 8'(i);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_dout = 8'h00;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

        // Vector table: fill, read back, boot lock, out-of-range, read-before-write.
        for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, 0, 16'(i), 8'(i + 1), 0, 0, 8'h00));
        for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 1, 0, 16'(i), 8'h00, 1, 0, 8'(i + 1)));
        tbl.push_back(mk(1, 0, 1, 16'd2,      8'h55, 0, 1, 8'h10));
        tbl.push_back(mk(0, 1, 0, 16'd2,      8'h00, 1, 0, 8'h03));
        tbl.push_back(mk(1, 0, 0, 16'h0010,   8'h77, 0, 1, 8'h03));
        tbl.push_back(mk(0, 1, 0, 16'h0010,   8'h00, 0, 1, 8'h03));
        tbl.push_back(mk(0, 1, 0, 16'hFFFF,   8'h00, 0, 1, 8'h03));
        tbl.push_back(mk(0, 1, 0, 16'd0,      8'h00, 1, 0, 8'h01));
        tbl.push_back(mk(1, 1, 1, 16'd4,      8'hEE, 1, 1, 8'h05));
        tbl.push_back(mk(0, 1, 0, 16'd4,      8'h00, 1, 0, 8'h05));
        tbl.push_back(mk(1, 1, 0, 16'd6,      8'h99, 1, 0, 8'h07));
        tbl.push_back(mk(0, 1, 0, 16'd6,      8'h00, 1, 0, 8'h99));
        tbl.push_back(mk(0, 0, 0, 16'd6,      8'h00, 0, 0, 8'h99));

        do_reset("reset0");
        foreach (tbl[i]) begin
            @(negedge clk);
            wren = tbl[i].wr; rden = tbl[i].rd; boot_mode = tbl[i].bt;
            addr = tbl[i].a; data_in = tbl[i].din; train_mode = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].vld));
            check($sformatf("tbl%0d.acc_err", i),  32'(acc_err),  32'(tbl[i].err));
            check($sformatf("tbl%0d.data_out", i), 32'(data_out), 32'(tbl[i].dout));
        end

        // Clean training run, then read back pattern words.
        do_reset("reset1");
        run_training(1'b0, 1'b1, "train_ok");
        step(0, 1, 0, 16'd3,  8'h00, "post_train.a3");
        check("post_train.a3_const", 32'(data_out), 32'hA6);
        step(0, 1, 0, 16'hF,  8'h00, "post_train.aF");
        check("post_train.aF_const", 32'(data_out), 32'hAA);

        // Training with a corrupted read-back word.
        run_training(1'b1, 1'b0, "train_bad");

        // Abort partway through the fill phase.
        @(negedge clk);
        idle_inputs();
        train_mode = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort.busy@%0d", k), 32'(train_busy), 32'h1);
        end
        @(negedge clk);
        train_mode = 1'b0;
        @(posedge clk);
        #1;
        check("abort.busy_clr", 32'(train_busy), 32'h0);
        check("abort.done",     32'(train_done), 32'h0);
        step(0, 1, 0, 16'd0, 8'h00, "abort.rd0");
        step(1, 1, 0, 16'd1, 8'h3C, "abort.rbw1");
        step(0, 1, 0, 16'd1, 8'h00, "abort.rd1");

        // Randomized functional traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic        wr;
            logic        rd;
            logic        bt;
            logic [15:0] a;
            int          sel;
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            bt  = ($urandom_range(0, 3) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = 16'(DEPTH + int'($urandom_range(0, 1000)));
            else if (sel == 1) a = 16'hFFFF;
            else               a = 16'($urandom_range(0, DEPTH - 1));
            step(wr, rd, bt, a, 8'($urandom), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
